// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - single-transaction initiator for the shared altitude/battery datapath
//
// Accepts one operand request at a time, drives it onto the datapath operand
// inputs and waits out the datapath pipeline latency. It then captures the
// selected 16-bit signed result and holds it on the response port until the
// consumer takes it.
//
// Parameters
//   LAT    datapath latency in clk edges from operand change to valid result (1..15)
//   CNT_W  width of the per-equation completion counters
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      request handshake; req_ready is high only in IDLE
//   req_sel                  0 = altitude (x1*3 + x2*5), 1 = battery (v*t + c)
//   req_x1..req_c            signed 8-bit operands
//   dp_x1..dp_c, dp_sel_eq   registered operands and equation select to the datapath
//   dp_result_a/dp_result_b  datapath altitude/battery results
//   rsp_valid/rsp_ready      response handshake
//   rsp_sel, rsp_data        equation and signed result of the held response
//   alt_done, bat_done       wrapping counts of delivered responses per equation

module datapath_sequencer #(
    parameter int LAT   = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sel,
    input  logic [7:0]       req_x1,
    input  logic [7:0]       req_x2,
    input  logic [7:0]       req_v,
    input  logic [7:0]       req_t,
    input  logic [7:0]       req_c,
    output logic [7:0]       dp_x1,
    output logic [7:0]       dp_x2,
    output logic [7:0]       dp_v,
    output logic [7:0]       dp_t,
    output logic [7:0]       dp_c,
    output logic             dp_sel_eq,
    input  logic [15:0]      dp_result_a,
    input  logic [15:0]      dp_result_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_sel,
    output logic [15:0]      rsp_data,
    output logic [CNT_W-1:0] alt_done,
    output logic [CNT_W-1:0] bat_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CAPT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t     state;
    state_t     state_n;
    logic [3:0] wait_cnt;

    // Single-cycle strobes decoded from the FSM
    logic       load;
    logic       capture;
    logic       retire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        req_ready = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: begin
                // req_ready is a pure state decode so a requester may wait on it
                req_ready = 1'b1;
                if (req_valid) begin
                    load    = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                // Counter was loaded with LAT, so WAIT spans exactly LAT edges
                if (wait_cnt == 4'd1) begin
                    state_n = S_CAPT;
                end
            end
            S_CAPT: begin
                capture = 1'b1;
                state_n = S_RESP;
            end
            S_RESP: begin
                // rsp_valid is always high in RESP, so rsp_ready alone completes
                if (rsp_ready) begin
                    retire  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            dp_x1     <= 8'd0;
            dp_x2     <= 8'd0;
            dp_v      <= 8'd0;
            dp_t      <= 8'd0;
            dp_c      <= 8'd0;
            dp_sel_eq <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sel   <= 1'b0;
            rsp_data  <= 16'd0;
            alt_done  <= '0;
            bat_done  <= '0;
        end else begin
            // Operands stay on the datapath after the transaction; only a new
            // accept replaces them.
            if (load) begin
                dp_x1     <= req_x1;
                dp_x2     <= req_x2;
                dp_v      <= req_v;
                dp_t      <= req_t;
                dp_c      <= req_c;
                dp_sel_eq <= req_sel;
                wait_cnt  <= LAT_CNT;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end

            if (capture) begin
                rsp_data  <= dp_sel_eq ? dp_result_b : dp_result_a;
                rsp_sel   <= dp_sel_eq;
                rsp_valid <= 1'b1;
            end

            if (retire) begin
                rsp_valid <= 1'b0;
                if (rsp_sel) begin
                    bat_done <= bat_done + CNT_W'(1);
                end else begin
                    alt_done <= alt_done + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - scoreboard bench for datapath_sequencer with a datapath model

module tb_datapath_sequencer;

    localparam int LAT   = 2;
    localparam int CNT_W = 4;
    localparam int TMO   = 50;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_sel;
    logic [7:0]       req_x1, req_x2, req_v, req_t, req_c;
    logic [7:0]       dp_x1, dp_x2, dp_v, dp_t, dp_c;
    logic             dp_sel_eq;
    logic [15:0]      dp_result_a, dp_result_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_sel;
    logic [15:0]      rsp_data;
    logic [CNT_W-1:0] alt_done, bat_done;

    datapath_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_v      (req_v),
        .req_t      (req_t),
        .req_c      (req_c),
        .dp_x1      (dp_x1),
        .dp_x2      (dp_x2),
        .dp_v       (dp_v),
        .dp_t       (dp_t),
        .dp_c       (dp_c),
        .dp_sel_eq  (dp_sel_eq),
        .dp_result_a(dp_result_a),
        .dp_result_b(dp_result_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_sel    (rsp_sel),
        .rsp_data   (rsp_data),
        .alt_done   (alt_done),
        .bat_done   (bat_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: combinational in, LAT register stages out
    logic signed [15:0] pa [LAT];
    logic signed [15:0] pb [LAT];
    always @(posedge clk) begin
        pa[0] <= 16'($signed(dp_x1) * 16'sd3 + $signed(dp_x2) * 16'sd5);
        pb[0] <= 16'($signed(dp_v) * $signed(dp_t) + $signed(dp_c));
        for (int i = 1; i < LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
        end
    end
    assign dp_result_a = pa[LAT-1];
    assign dp_result_b = pb[LAT-1];

    typedef struct {
        int sel;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_alt = 0;
    int   exp_bat = 0;
    int   acc_cyc = 0;

    function automatic int f_alt(input int x1, input int x2);
        return x1 * 3 + x2 * 5;
    endfunction

    function automatic int f_bat(input int v, input int t, input int c);
        return v * t + c;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int sel, input int x1, input int x2,
                             input int v, input int t, input int c);
        req_sel = sel[0];
        req_x1  = 8'(x1);
        req_x2  = 8'(x2);
        req_v   = 8'(v);
        req_t   = 8'(t);
        req_c   = 8'(c);
    endtask

    task automatic push_exp(input int sel, input int x1, input int x2,
                            input int v, input int t, input int c);
        exp_t e;
        e.sel  = sel;
        e.data = sel ? f_bat(v, t, c) : f_alt(x1, x2);
        exp_q.push_back(e);
    endtask

    // Issue one request; it is accepted at the next edge since req_ready is high.
    task automatic send(input int sel, input int x1, input int x2,
                        input int v, input int t, input int c, input bit push);
        int n = 0;
        while (!req_ready && n < TMO) begin
            tick();
            n++;
        end
        chk("req_ready_wait", int'(req_ready), 1);
        drive_req(sel, x1, x2, v, t, c);
        req_valid = 1'b1;
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        drive_req(0, 99, -99, 77, -77, 55);
        if (push) push_exp(sel, x1, x2, v, t, c);
    endtask

    // Compare the held response against the scoreboard head, then complete it.
    task automatic take_rsp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_nonempty"}, 0, 1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_sel"}, int'(rsp_sel), e.sel);
        chk({tag, "_data"}, int'($signed(rsp_data)), e.data);
        rsp_ready = 1'b1;
        tick();
        if (e.sel != 0) exp_bat++; else exp_alt++;
        chk({tag, "_valid_drop"}, int'(rsp_valid), 0);
        chk({tag, "_alt_done"}, int'(alt_done), exp_alt % (1 << CNT_W));
        chk({tag, "_bat_done"}, int'(bat_done), exp_bat % (1 << CNT_W));
    endtask

    task automatic recv(input string tag);
        int n = 0;
        while (!rsp_valid && n < TMO) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, int'(rsp_valid), 1);
        chk({tag, "_latency"}, cyc - acc_cyc, LAT + 1);
        take_rsp(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_alt = 0;
        exp_bat = 0;
        exp_q.delete();
    endtask

    initial begin
        int prev;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, 0, 0, 0, 0, 0);

        // Power-on reset
        do_reset();
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_dp_x1", int'(dp_x1), 0);
        chk("rst_alt_done", int'(alt_done), 0);

        // Altitude: 3*3 + 4*5 = 29
        send(0, 3, 4, 0, 0, 0, 1'b1);
        chk("alt_busy", int'(req_ready), 0);
        recv("alt");
        chk("alt_done_one", int'(alt_done), 1);
        chk("dp_hold_x1", int'(dp_x1), 3);

        // Battery: 2*5+16 = 26, (-3)*(-2)+10 = 16
        send(1, 0, 0, 2, 5, 16, 1'b1);
        recv("bat1");
        send(1, 0, 0, -3, -2, 10, 1'b1);
        recv("bat2");
        chk("bat_done_two", int'(bat_done), 2);

        // Backpressure: hold response 10 cycles while a request waits
        rsp_ready = 1'b0;
        send(0, -7, 9, 0, 0, 0, 1'b1);
        begin
            int n = 0;
            while (!rsp_valid && n < TMO) begin
                tick();
                n++;
            end
        end
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        drive_req(1, 0, 0, 5, 6, -1);
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", int'($signed(rsp_data)), f_alt(-7, 9));
            chk("bp_hold_valid", int'(rsp_valid), 1);
            chk("bp_req_ready", int'(req_ready), 0);
        end
        take_rsp("bp");
        chk("bp_idle_ready", int'(req_ready), 1);
        tick();
        acc_cyc   = cyc;
        req_valid = 1'b0;
        push_exp(1, 0, 0, 5, 6, -1);
        chk("bp_second_accept", int'(req_ready), 0);
        recv("bp_next");

        // Alternating stream with continuous rsp_ready
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            send(i % 2, 10, 15, 12, 8, 20, 1'b1);
            if (i > 0) chk("alt_stream_spacing", acc_cyc - prev, LAT + 3);
            prev = acc_cyc;
            recv("stream");
        end

        // Reset in the middle of WAIT drops the transaction
        do_reset();
        send(0, 1, 1, 0, 0, 0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_sel", int'(rsp_sel), 0);
        chk("mid_rst_rsp_data", int'(rsp_data), 0);
        chk("mid_rst_dp_x1", int'(dp_x1), 0);
        chk("mid_rst_alt_done", int'(alt_done), 0);
        chk("mid_rst_bat_done", int'(bat_done), 0);
        rst = 1'b0;
        tick();
        chk("mid_rst_req_ready", int'(req_ready), 1);
        for (int i = 0; i < LAT + 5; i++) begin
            tick();
            chk("mid_rst_no_rsp", int'(rsp_valid), 0);
        end

        // Counter wrap: 17 altitude responses on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            send(0, i, -i, 0, 0, 0, 1'b1);
            recv("wrap");
        end
        chk("wrap_alt_done", int'(alt_done), 1);
        chk("wrap_bat_done", int'(bat_done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
